// File: rtl/semaforo_pkg.sv
// Shared types and lamp codes for the N-approach traffic-light controller.
// Imported by semaforo_contador and semaforo_n.
package semaforo_pkg;

    typedef enum logic [1:0] {
        VERDE    = 2'd0,
        AMARELO  = 2'd1,
        VERMELHO = 2'd2,
        PEDESTRE = 2'd3
    } estado_t;

    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;

endpackage

// File: rtl/semaforo_contador.sv
// Phase counter: counts elapsed cycles in the current state and flags the last one.
// A zero duration is treated as one cycle.
module semaforo_contador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] cnt,
    output logic         fim
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   alvo;
    logic [W:0]   prox;

    // One extra bit so cnt+1 cannot wrap when compared against a full-scale duration
    always_comb begin
        alvo  = (d == '0) ? (W+1)'(1) : {1'b0, d};
        prox  = {1'b0, cnt_q} + (W+1)'(1);
        fim   = (prox >= alvo);
        cnt_d = clr ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/semaforo_n.sv
// Round-robin traffic-light controller for N_VIAS approaches with all-red clearance.
// Define SEMAFORO_PED_EN to build the latched pedestrian request and PEDESTRE phase.
module semaforo_n
    import semaforo_pkg::*;
#(
    parameter  int N_VIAS = 2,
    parameter  int W      = 8,
    localparam int IW     = $clog2(N_VIAS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bt,
    input  logic [W-1:0]          t_verde,
    input  logic [W-1:0]          t_amarelo,
    input  logic [W-1:0]          t_vermelho,
    input  logic [W-1:0]          t_pedestre,
    output logic [3*N_VIAS-1:0]   luz,
    output logic                  ped,
    output logic [IW-1:0]         via
);

    estado_t      state_q, state_d;
    logic [IW-1:0] via_q, via_d, via_prox;
    logic [W-1:0] d_sel;
    logic [W-1:0] cnt;
    logic         fim;

`ifdef SEMAFORO_PED_EN
    logic pend_q, pend_d;
    logic ent_ped;
`else
    logic unused_ped_inputs;
    assign unused_ped_inputs = ^{bt, t_pedestre};
`endif

    // Every state exits on fim, so the counter clears on exactly those edges
    semaforo_contador #(.W(W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (fim),
        .d   (d_sel),
        .cnt (cnt),
        .fim (fim)
    );

    always_comb begin
        d_sel = t_verde;
        case (state_q)
            VERDE:    d_sel = t_verde;
            AMARELO:  d_sel = t_amarelo;
            VERMELHO: d_sel = t_vermelho;
`ifdef SEMAFORO_PED_EN
            default:  d_sel = t_pedestre;
`else
            default:  d_sel = t_vermelho;
`endif
        endcase
    end

    always_comb begin
        via_prox = (via_q == IW'(N_VIAS-1)) ? '0 : via_q + IW'(1);
        state_d  = state_q;
        via_d    = via_q;
`ifdef SEMAFORO_PED_EN
        ent_ped  = 1'b0;
`endif
        if (fim) begin
            case (state_q)
                VERDE:   state_d = AMARELO;
                AMARELO: state_d = VERMELHO;
                VERMELHO: begin
`ifdef SEMAFORO_PED_EN
                    if (pend_q) begin
                        state_d = PEDESTRE;
                        ent_ped = 1'b1;
                    end else begin
                        state_d = VERDE;
                        via_d   = via_prox;
                    end
`else
                    state_d = VERDE;
                    via_d   = via_prox;
`endif
                end
                default: begin
                    state_d = VERDE;
                    via_d   = via_prox;
                end
            endcase
        end
    end

`ifdef SEMAFORO_PED_EN
    // Entering PEDESTRE serves the request, even if bt is high on that same edge
    always_comb begin
        pend_d = ent_ped ? 1'b0 : (pend_q | bt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= VERDE;
            via_q   <= '0;
        end else begin
            state_q <= state_d;
            via_q   <= via_d;
        end
    end

    always_comb begin
        luz = '0;
        for (int k = 0; k < N_VIAS; k++) begin
            luz[3*k +: 3] = LUZ_VERMELHO;
            if (via_q == IW'(k)) begin
                if (state_q == VERDE) begin
                    luz[3*k +: 3] = LUZ_VERDE;
                end else if (state_q == AMARELO) begin
                    luz[3*k +: 3] = LUZ_AMARELO;
                end
            end
        end
`ifdef SEMAFORO_PED_EN
        ped = (state_q == PEDESTRE);
`else
        ped = 1'b0;
`endif
        via = via_q;
    end

endmodule

// File: tb/tb_semaforo_n.sv
// Directed bench for semaforo_n: a 2-approach instance for phase timing, pedestrian
// service and reset, and a 4-approach instance for round-robin order and wrap.
module tb_semaforo_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, bt;
    logic [7:0]  tv, ta, tr, tp;
    logic [5:0]  luz;
    logic        ped;
    logic [0:0]  via;

    logic        rst4, bt4;
    logic [7:0]  t_one;
    logic [11:0] luz4;
    logic        ped4;
    logic [1:0]  via4;

    int n_chk  = 0;
    int n_fail = 0;

    semaforo_n #(.N_VIAS(2), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bt         (bt),
        .t_verde    (tv),
        .t_amarelo  (ta),
        .t_vermelho (tr),
        .t_pedestre (tp),
        .luz        (luz),
        .ped        (ped),
        .via        (via)
    );

    semaforo_n #(.N_VIAS(4), .W(8)) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .bt         (bt4),
        .t_verde    (t_one),
        .t_amarelo  (t_one),
        .t_vermelho (t_one),
        .t_pedestre (t_one),
        .luz        (luz4),
        .ped        (ped4),
        .via        (via4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [5:0] luz_e, input logic ped_e,
                        input logic via_e);
        chk({tag, ".luz"}, 32'(luz), 32'(luz_e));
        chk({tag, ".ped"}, 32'(ped), 32'(ped_e));
        chk({tag, ".via"}, 32'(via), 32'(via_e));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp4;
        int          ph, v, nonred;

        rst = 1'b0; rst4 = 1'b0; bt = 1'b0; bt4 = 1'b0;
        tv = 8'd1; ta = 8'd3; tr = 8'd2; tp = 8'd2; t_one = 8'd1;
`ifndef SEMAFORO_PED_EN
        bt = 1'b1;
`endif
        step(2);
        look("rst", 6'b100_001, 1'b0, 1'b0);
        chk("rst.cnt", 32'(dut.cnt), 32'd0);

        // First round from reset: G=1, Y=3, R=2
        rst = 1'b1;
        look("s1.v0", 6'b100_001, 1'b0, 1'b0);
        step(1); look("s1.a0_1", 6'b100_010, 1'b0, 1'b0);
        step(1); look("s1.a0_2", 6'b100_010, 1'b0, 1'b0);
        step(1); look("s1.a0_3", 6'b100_010, 1'b0, 1'b0);
        step(1); look("s1.r_1", 6'b100_100, 1'b0, 1'b0);
        step(1); look("s1.r_2", 6'b100_100, 1'b0, 1'b0);
        step(1); look("s1.v1", 6'b001_100, 1'b0, 1'b1);
        step(1); look("s1.a1", 6'b010_100, 1'b0, 1'b1);
        step(3); look("s1.r1", 6'b100_100, 1'b0, 1'b1);
        step(2); look("s1.v0_again", 6'b100_001, 1'b0, 1'b0);
        bt = 1'b0;

        // One-edge button press during approach 0 green
        bt = 1'b1;
        step(1);
        bt = 1'b0;
        look("s2.a0", 6'b100_010, 1'b0, 1'b0);
        step(3); look("s2.r_1", 6'b100_100, 1'b0, 1'b0);
        step(1); look("s2.r_2", 6'b100_100, 1'b0, 1'b0);
        step(1);
`ifdef SEMAFORO_PED_EN
        look("s2.p_1", 6'b100_100, 1'b1, 1'b0);
        step(1); look("s2.p_2", 6'b100_100, 1'b1, 1'b0);
        step(1);
        chk("s2.pend", 32'(dut.pend_q), 32'd0);
`endif
        look("s2.v1", 6'b001_100, 1'b0, 1'b1);

        // Async reset in approach 1 yellow with a request pending
        bt = 1'b1;
        step(1);
        bt = 1'b0;
        look("s3.a1", 6'b010_100, 1'b0, 1'b1);
`ifdef SEMAFORO_PED_EN
        chk("s3.pend_set", 32'(dut.pend_q), 32'd1);
`endif
        step(1);
        look("s3.a1_2", 6'b010_100, 1'b0, 1'b1);
        rst = 1'b0;
        #2;
        look("s3.rst", 6'b100_001, 1'b0, 1'b0);
        chk("s3.cnt", 32'(dut.cnt), 32'd0);
`ifdef SEMAFORO_PED_EN
        chk("s3.pend_clr", 32'(dut.pend_q), 32'd0);
`endif
        rst = 1'b1;
        step(1); look("s3.a0", 6'b100_010, 1'b0, 1'b0);
        step(3); look("s3.r", 6'b100_100, 1'b0, 1'b0);
        step(2); look("s3.v1_noped", 6'b001_100, 1'b0, 1'b1);

        // Zero yellow duration, then green shortened below the elapsed count
        ta = 8'd0;
        step(1); look("s4.a1", 6'b010_100, 1'b0, 1'b1);
        step(1); look("s4.r_after_1y", 6'b100_100, 1'b0, 1'b1);
        tv = 8'd10;
        step(2); look("s4.v0", 6'b100_001, 1'b0, 1'b0);
        step(4); look("s4.v0_5th", 6'b100_001, 1'b0, 1'b0);
        chk("s4.cnt", 32'(dut.cnt), 32'd4);
        tv = 8'd2;
        step(1); look("s4.a0_early", 6'b100_010, 1'b0, 1'b0);
        tv = 8'd1; ta = 8'd3;

        // Four approaches, all durations 1: V,A,R per approach, wrapping 3 -> 0
        rst4 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            ph   = i % 3;
            v    = (i / 3) % 4;
            exp4 = 12'b100_100_100_100;
            if (ph == 0) exp4[3*v +: 3] = 3'b001;
            if (ph == 1) exp4[3*v +: 3] = 3'b010;
            chk($sformatf("s5.luz[%0d]", i), 32'(luz4), 32'(exp4));
            chk($sformatf("s5.via[%0d]", i), 32'(via4), 32'(v));
            chk($sformatf("s5.ped[%0d]", i), 32'(ped4), 32'd0);
            nonred = 0;
            for (int k = 0; k < 4; k++) begin
                if (luz4[3*k +: 3] != 3'b100) nonred++;
            end
            chk($sformatf("s5.one_lane[%0d]", i), 32'(nonred <= 1), 32'd1);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/semaforo_n.md
# semaforo_n

Parametrised traffic-light controller: successor to the two-way `semaforo`, generalised to `N_VIAS` approaches served round-robin. Adds runtime-programmable phase durations, an all-red clearance between approaches, and an optional latched pedestrian phase. It sits between the board clock/reset/button inputs and the lamp drivers.

## Interface

- `N_VIAS`, default 2, number of vehicle approaches; legal range 2..8.
- `W`, default 8, width of the duration inputs and of the phase counter.
- `IW`, default `$clog2(N_VIAS)`, width of the active-approach index; derived, never overridden.

Ports:

- `clk` input 1: sole clock; rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `bt` input 1: pedestrian request, sampled on `clk`.
- `t_verde` input W: green duration, in cycles.
- `t_amarelo` input W: yellow duration, in cycles.
- `t_vermelho` input W: all-red clearance duration, in cycles.
- `t_pedestre` input W: pedestrian phase duration, in cycles.
- `luz` output 3*N_VIAS: per-approach lamp code, approach k in bits `[3k+2:3k]`. Codes: `3'b001` green, `3'b010` yellow, `3'b100` red.
- `ped` output 1: pedestrian walk lamp.
- `via` output IW: index of the approach currently owning green or yellow.

## Operation

- FSM states: VERDE, AMARELO, VERMELHO (all-red clearance), PEDESTRE.
- Transitions:
  - VERDE -> AMARELO
  - AMARELO -> VERMELHO
  - VERMELHO -> PEDESTRE if `pend`, else VERDE with `via` advanced.
  - PEDESTRE -> VERDE with `via` advanced.
- `via` advance: `via+1`, wrapping `N_VIAS-1 -> 0`.
- Phase counter `cnt` (W bits) counts elapsed cycles in the current state and clears to 0 on every transition.
- A state is left on the edge where `cnt+1 >= max(d,1)`, where `d` is that state's duration input. A zero duration therefore behaves as 1, and the maximum duration is `2^W-1`.
- Duration inputs are compared live. A change mid-phase takes effect immediately. If the new value is at or below the elapsed count, the state is left on the next edge.
- Outputs are decoded from the registered state only (Moore):
  - VERDE/AMARELO: `luz[via]` is green/yellow; all other approaches are red.
  - VERMELHO/PEDESTRE: all approaches are red.
  - `ped`=1 only in PEDESTRE.
- Pedestrian latch `pend`:
  - Set on any edge where `bt`=1.
  - Cleared on the edge entering PEDESTRE. If `bt`=1 on that same edge, clear wins: the request is served.
  - `bt` asserted during PEDESTRE sets `pend` for the next round.
  - Multiple presses before service collapse to one request.

## Timing

- Reset (`rst`=0, asynchronous):
  - state VERDE, `via`=0, `cnt`=0, `pend`=0.
  - `luz` = approach 0 green, others red.
  - `ped`=0.
  - Reset mid-phase aborts that phase at once. No yellow or clearance is inserted.
- The first phase after reset deasserts lasts exactly `max(t_verde,1)` rising edges.
- One full round without a request takes `N_VIAS*(G+Y+R)` cycles, with G/Y/R the clamped durations. A served request adds `max(t_pedestre,1)` once.
- Latency from `bt` to `ped`:
  - PEDESTRE begins at the first VERMELHO exit after the edge sampling `bt`.
  - A `bt` sampled on the very edge that leaves VERMELHO is not served that round (`pend` is updated on the same edge as the decision).
- `luz`, `ped` and `via` change only on rising `clk` edges, or asynchronously on reset.

## Configuration

- `SEMAFORO_PED_EN` defined: the pedestrian latch and the PEDESTRE state are present, as described above.
- `SEMAFORO_PED_EN` undefined:
  - `bt` and `t_pedestre` are ignored.
  - `pend` is not built.
  - `ped` is tied to 0.
  - VERMELHO always exits to VERDE.

## Structure

- Package `semaforo_pkg` holds:
  - the state enum (`VERDE`, `AMARELO`, `VERMELHO`, `PEDESTRE`);
  - the lamp constants `LUZ_VERDE`, `LUZ_AMARELO`, `LUZ_VERMELHO`.
- Sub-module `semaforo_contador`: W-bit phase counter with synchronous clear, async active-low reset and a `fim` output (`cnt+1 >= max(d,1)`). It is instantiated once, with `d` muxed by state.

## Test plan

Default bench: `N_VIAS`=2, W=8, `t_verde`=1, `t_amarelo`=3, `t_vermelho`=2, `t_pedestre`=2, `SEMAFORO_PED_EN` defined.

- Reset held, then released with `bt`=0 -> `luz`=`100_001` for 1 cycle, `100_010` for 3, `100_100` for 2, then `001_100` with `via`=1; `ped` stays 0.
- `bt` pulsed for one edge during approach 0 green -> after that approach's 2 all-red cycles, `ped`=1 for 2 cycles with `luz`=`100_100`, then approach 1 green; `pend` is cleared.
- `rst` pulsed low for 1 cycle while in AMARELO of approach 1 -> immediately approach 0 green, `via`=0, `pend`=0, `cnt`=0.
- `t_amarelo`=0 -> yellow lasts exactly 1 cycle. `t_verde` lowered from 10 to 2 after 5 green cycles -> AMARELO is entered on the next edge.
- `N_VIAS`=4, no requests -> green visits approaches 0, 1, 2, 3, 0 in order; `via` wraps 3 -> 0; never more than one approach non-red.
- `SEMAFORO_PED_EN` undefined with `bt` held at 1 -> `ped` always 0; the round is identical to the first scenario.
